// File: rtl/panda_instr_mem.sv
// Instruction memory for the Panda fetch port: zero-latency reads plus a byte-serial image loader.
// Optional PANDA_IMEM_ERR_EN adds a sticky fetch_err_o flag for unmapped fetches.
module panda_instr_mem #(
  parameter int unsigned Depth    = 1024,
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter logic [31:0] NopInstr = 32'h0000_0013
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [31:0]             instr_addr_i,
  output logic [31:0]             instr_rdata_o,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [7:0]              load_byte_i,
  input  logic                    load_last_i,
  output logic                    load_busy_o,
`ifdef PANDA_IMEM_ERR_EN
  output logic                    fetch_err_o,
`endif
  output logic [$clog2(Depth):0]  load_words_o
);

  localparam int unsigned IdxW   = $clog2(Depth);
  localparam int unsigned WordsW = IdxW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [IdxW-1:0]     wptr_q, wptr_d;
  logic [23:0]         asm_q, asm_d;
  logic [WordsW-1:0]   words_q, words_d, words_inc_c;
  logic                load_ready_c, load_busy_c, accept_c;
  logic                mem_we_c;
  logic [31:0]         mem_wdata_c;
  logic [31:0]         mem_q [Depth];
  logic [31:0]         offset_c;
  logic                fetch_hit_c;
  logic                unused_c;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c) state_d = load_last_i ? COMMIT : LOAD;
      LOAD:    if (accept_c && load_last_i) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; busy rises with the first offered byte so the core stalls immediately
  always_comb begin
    load_ready_c = 1'b1;
    load_busy_c  = 1'b0;
    unique case (state_q)
      IDLE:    load_busy_c = load_valid_i;
      LOAD:    load_busy_c = 1'b1;
      COMMIT: begin
        load_ready_c = 1'b0;
        load_busy_c  = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept_c    = load_valid_i && load_ready_c;
  assign words_inc_c = (words_q == WordsW'(Depth)) ? words_q : words_q + WordsW'(1);

  // Byte assembly and word write-back; lane 3 bypasses the assembly register
  always_comb begin
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    wptr_d      = wptr_q;
    words_d     = words_q;
    mem_we_c    = 1'b0;
    mem_wdata_c = '0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          wptr_d     = '0;
          words_d    = '0;
          asm_d      = 24'(load_byte_i);
          byte_idx_d = 2'd1;
        end
      end
      LOAD: begin
        if (accept_c) begin
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: asm_d[7:0]   = load_byte_i;
            2'd1: asm_d[15:8]  = load_byte_i;
            2'd2: asm_d[23:16] = load_byte_i;
            default: begin
              mem_we_c    = 1'b1;
              mem_wdata_c = {load_byte_i, asm_q};
              wptr_d      = wptr_q + IdxW'(1);
              words_d     = words_inc_c;
              asm_d       = '0;
            end
          endcase
        end
      end
      COMMIT: begin
        if (byte_idx_q != 2'd0) begin
          mem_we_c    = 1'b1;
          mem_wdata_c = {8'h00, asm_q};
          words_d     = words_inc_c;
        end
        byte_idx_d = '0;
        asm_d      = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_idx_q <= '0;
      wptr_q     <= '0;
      asm_q      <= '0;
      words_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      wptr_q     <= wptr_d;
      asm_q      <= asm_d;
      words_q    <= words_d;
    end
  end

  // Storage array is intentionally left without reset
  always_ff @(posedge clk_i) begin
    if (mem_we_c) mem_q[wptr_q] <= mem_wdata_c;
  end

  // Fetch decode: a negative offset wraps to a huge index and misses
  assign offset_c    = instr_addr_i - BaseAddr;
  assign fetch_hit_c = (offset_c[31:IdxW+2] == '0);
  assign unused_c    = ^offset_c[1:0];

  assign instr_rdata_o = (fetch_hit_c && !load_busy_c) ? mem_q[offset_c[IdxW+1:2]] : NopInstr;
  assign load_ready_o  = load_ready_c;
  assign load_busy_o   = load_busy_c;
  assign load_words_o  = words_q;

`ifdef PANDA_IMEM_ERR_EN
  logic fetch_err_q;

  // Sticky miss flag, cleared when a new load session starts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         fetch_err_q <= 1'b0;
    else if (state_q == IDLE && accept_c) fetch_err_q <= 1'b0;
    else if (!fetch_hit_c && !load_busy_c) fetch_err_q <= 1'b1;
  end

  assign fetch_err_o = fetch_err_q;
`endif

endmodule
